// File: rtl/tx_load_sched_pkg.sv
// Shared types for the UART transmit holding-register load scheduler.
package tx_load_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_BUSY  = 2'd3
  } sched_state_e;

  localparam int DW_DEF = 8;

endpackage

// File: rtl/tx_load_sched_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time goes.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic any_o
);

  assign any_o = req0_i | req1_i;
  assign win_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/tx_load_sched.sv
// Arbitrates host/echo loads into the TX holding register and sequences the shift engine.
// IDLE -> LOAD (gnt, thr_load) -> START (tx_start) -> BUSY until tx_done or timeout.
module tx_load_sched
  import tx_load_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TO_W    = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  output logic          thr_load,
  output logic [DW-1:0] thr_d,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          txrdy,
  input  logic          err_clr,
  output logic          err_tmo,
  output logic          err_spur
);

  localparam logic [TO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  sched_state_e    state_q;
  logic            last_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            gnt0_q, gnt1_q, thr_load_q, tx_start_q, txrdy_q;
  logic            err_tmo_q, err_spur_q;
  logic [DW-1:0]   thr_d_q;
  logic            arb_win, arb_any;

  rr_arb2 u_arb (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (last_q),
    .win_o  (arb_win),
    .any_o  (arb_any)
  );

  assign cnt_d = cnt_q + TO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      thr_load_q <= 1'b0;
      thr_d_q    <= '0;
      tx_start_q <= 1'b0;
      txrdy_q    <= 1'b1;
      err_tmo_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      thr_load_q <= 1'b0;
      tx_start_q <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (err_clr) begin
        err_tmo_q  <= 1'b0;
        err_spur_q <= 1'b0;
      end
      if (tx_done && state_q != ST_BUSY) err_spur_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt0_q     <= ~arb_win;
            gnt1_q     <= arb_win;
            thr_load_q <= 1'b1;
            thr_d_q    <= arb_win ? data1 : data0;
            if (req0 && req1) last_q <= arb_win;
            txrdy_q    <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_start_q <= 1'b1;
          state_q    <= ST_START;
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (tx_done) begin
            txrdy_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
            err_tmo_q <= 1'b1;
            txrdy_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign thr_load = thr_load_q;
  assign thr_d    = thr_d_q;
  assign tx_start = tx_start_q;
  assign txrdy    = txrdy_q;
  assign err_tmo  = err_tmo_q;
  assign err_spur = err_spur_q;

endmodule
